// File: rtl/shifter_input_ctrl.sv
// Push-button front-end for the mode/state shifter: sync, debounce, left/right
// auto-repeat and fixed-priority arbitration into one-hot command pulses.
module shifter_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_confirm_i,
  input  logic       enable_i,
  output logic       up_o,
  output logic       left_o,
  output logic       right_o,
  output logic       confirm_o,
  output logic [3:0] level_o
);

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W    = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  typedef enum logic {RPT_IDLE, RPT_ARMED} rpt_state_e;

  // Bit order everywhere: {up, left, right, confirm}
  logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BTN-1:0] level_q, level_d, level_prev_q, level_prev_d;
  logic [NUM_BTN-1:0] pending_q, pending_d, pulse_q, pulse_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]    db_cnt_d [NUM_BTN];

  // Repeat channels: index 0 = right, 1 = left
  rpt_state_e         rpt_state_q [2];
  rpt_state_e         rpt_state_d [2];
  logic [RP_W-1:0]    rpt_cnt_q [2];
  logic [RP_W-1:0]    rpt_cnt_d [2];
  logic [1:0]         rpt_fire;
  logic [1:0]         rpt_rise;
  logic [1:0]         rpt_fall;

  logic [NUM_BTN-1:0] rise, fall, set_ev, grant;

  assign sync1_d      = {btn_up_i, btn_left_i, btn_right_i, btn_confirm_i};
  assign sync2_d      = sync1_q;
  assign level_prev_d = level_q;
  assign rise         = level_q & ~level_prev_q;
  assign fall         = ~level_q & level_prev_q;
  assign rpt_rise     = rise[2:1];
  assign rpt_fall     = fall[2:1];

  // Debounce: count consecutive cycles where the synced value disagrees with the level
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Auto-repeat: count down from the rise, fire at zero, then reload with the period
  always_comb begin
    rpt_fire = '0;
    for (int j = 0; j < 2; j++) begin
      rpt_state_d[j] = rpt_state_q[j];
      rpt_cnt_d[j]   = rpt_cnt_q[j];
      case (rpt_state_q[j])
        RPT_IDLE: begin
          if (rpt_rise[j]) begin
            rpt_state_d[j] = RPT_ARMED;
            rpt_cnt_d[j]   = RP_W'(REPEAT_DELAY - 1);
          end
        end
        RPT_ARMED: begin
          if (rpt_fall[j]) begin
            rpt_state_d[j] = RPT_IDLE;
            rpt_cnt_d[j]   = '0;
          end else if (rpt_cnt_q[j] == '0) begin
            rpt_fire[j]  = 1'b1;
            rpt_cnt_d[j] = RP_W'(REPEAT_PERIOD - 1);
          end else begin
            rpt_cnt_d[j] = rpt_cnt_q[j] - RP_W'(1);
          end
        end
        default: begin
          rpt_state_d[j] = RPT_IDLE;
          rpt_cnt_d[j]   = '0;
        end
      endcase
    end
  end

  // Fixed-priority grant; disable flushes everything queued
  always_comb begin
    set_ev = rise | {1'b0, rpt_fire, 1'b0};
    grant  = '0;
    if (pending_q[3])      grant = 4'b1000;
    else if (pending_q[2]) grant = 4'b0100;
    else if (pending_q[1]) grant = 4'b0010;
    else if (pending_q[0]) grant = 4'b0001;
    pending_d = (pending_q & ~grant) | set_ev;
    pulse_d   = grant;
    if (!enable_i) begin
      pending_d = '0;
      pulse_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        rpt_state_q[j] <= RPT_IDLE;
        rpt_cnt_q[j]   <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      pending_q    <= pending_d;
      pulse_q      <= pulse_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 2; j++) begin
        rpt_state_q[j] <= rpt_state_d[j];
        rpt_cnt_q[j]   <= rpt_cnt_d[j];
      end
    end
  end

  assign up_o      = pulse_q[3];
  assign left_o    = pulse_q[2];
  assign right_o   = pulse_q[1];
  assign confirm_o = pulse_q[0];
  assign level_o   = level_q;

endmodule

// File: tb/tb_shifter_input_ctrl.sv
// Directed bench for shifter_input_ctrl with D=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_shifter_input_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up, btn_left, btn_right, btn_confirm;
  logic       enable;
  logic       up_o, left_o, right_o, confirm_o;
  logic [3:0] level_o;
  logic [3:0] pulses;

  int total;
  int bad;

  assign pulses = {up_o, left_o, right_o, confirm_o};

  shifter_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_up_i      (btn_up),
    .btn_left_i    (btn_left),
    .btn_right_i   (btn_right),
    .btn_confirm_i (btn_confirm),
    .enable_i      (enable),
    .up_o          (up_o),
    .left_o        (left_o),
    .right_o       (right_o),
    .confirm_o     (confirm_o),
    .level_o       (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next edge; outputs then reflect that edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_confirm = 1'b0;
    enable = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    btn_up = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_confirm = 1'b0;
    enable = 1'b1;
    rst = 1'b0;
    step();
    step();
    total++;
    if (pulses !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", pulses);
    end
    total++;
    if (level_o !== 4'b0000) begin
      bad++; $display("FAIL reset_level got=%b want=0000", level_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_confirm();
    logic [3:0] exp_p, exp_l;
    do_reset();
    btn_confirm = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 12) btn_confirm = 1'b0;
      exp_p = (n == 8) ? 4'b0001 : 4'b0000;
      exp_l = (n >= 6 && n < 18) ? 4'b0001 : 4'b0000;
      total++;
      if (pulses !== exp_p) begin
        bad++; $display("FAIL confirm_pulse E%0d got=%b want=%b", n, pulses, exp_p);
      end
      total++;
      if (level_o !== exp_l) begin
        bad++; $display("FAIL confirm_level E%0d got=%b want=%b", n, level_o, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_p;
    do_reset();
    btn_right = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      step();
      if (n < 10) btn_right = ((n + 1) % 2) == 1;
      else        btn_right = 1'b1;
      exp_p = (n == 18 || n == 28) ? 4'b0010 : 4'b0000;
      total++;
      if (pulses !== exp_p) begin
        bad++; $display("FAIL bounce_pulse E%0d got=%b want=%b", n, pulses, exp_p);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_p;
    do_reset();
    btn_up = 1'b1; btn_left = 1'b1; btn_confirm = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      step();
      if (n == 20) begin
        btn_up = 1'b0; btn_left = 1'b0; btn_confirm = 1'b0;
      end
      exp_p = 4'b0000;
      if (n == 8)  exp_p = 4'b1000;
      if (n == 9 || n == 18 || n == 21 || n == 24 || n == 27) exp_p = 4'b0100;
      if (n == 10) exp_p = 4'b0001;
      total++;
      if (pulses !== exp_p) begin
        bad++; $display("FAIL priority_pulse E%0d got=%b want=%b", n, pulses, exp_p);
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] exp_p;
    do_reset();
    btn_left = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (n == 30) btn_left = 1'b0;
      exp_p = 4'b0000;
      if (n == 8 || (n >= 18 && n <= 33 && ((n - 18) % 3) == 0)) exp_p = 4'b0100;
      total++;
      if (n == 36) begin
        if ((pulses & 4'b1011) !== 4'b0000) begin
          bad++; $display("FAIL repeat_tail E%0d got=%b want=0x00", n, pulses);
        end
      end else if (pulses !== exp_p) begin
        bad++; $display("FAIL repeat_pulse E%0d got=%b want=%b", n, pulses, exp_p);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_p;
    do_reset();
    btn_confirm = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (n == 4)  enable = 1'b0;
      if (n == 12) enable = 1'b1;
      if (n == 25) btn_confirm = 1'b0;
      if (n == 35) btn_confirm = 1'b1;
      exp_p = (n == 43) ? 4'b0001 : 4'b0000;
      total++;
      if (pulses !== exp_p) begin
        bad++; $display("FAIL enable_pulse E%0d got=%b want=%b", n, pulses, exp_p);
      end
      if (n == 20) begin
        total++;
        if (level_o !== 4'b0001) begin
          bad++; $display("FAIL enable_level E%0d got=%b want=0001", n, level_o);
        end
      end
    end
    btn_confirm = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    btn_up = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 4) btn_up = 1'b0;
    end
    total++;
    if (level_o !== 4'b1000) begin
      bad++; $display("FAIL areset_pre_level got=%b want=1000", level_o);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (level_o !== 4'b0000) begin
      bad++; $display("FAIL areset_level got=%b want=0000", level_o);
    end
    total++;
    if (pulses !== 4'b0000) begin
      bad++; $display("FAIL areset_pulses got=%b want=0000", pulses);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      total++;
      if (pulses !== 4'b0000 || level_o !== 4'b0000) begin
        bad++; $display("FAIL areset_quiet C%0d got=%b/%b want=0000/0000", n, pulses, level_o);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_confirm();
    test_bounce();
    test_priority();
    test_repeat();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
